// File: rtl/seq_pkg.sv
// Shared types, constants and the next-animation selection for the animation sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWITCH = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    localparam logic [5:0] NUM_ANI_DEFAULT = 6'd46;

    // Fibonacci LFSR for x^6 + x^5 + 1: feedback is the XOR of bits 5 and 4.
    localparam int         LFSR_W    = 6;
    localparam logic [5:0] LFSR_TAPS = 6'b110000;
    localparam logic [5:0] LFSR_SEED = 6'h01;

    // Random pick folds the LFSR into range; a pick equal to the current index falls back to +1.
    function automatic logic [5:0] next_index(input logic [5:0] cur,
                                              input logic [5:0] num_ani,
                                              input logic [5:0] rnd,
                                              input logic       use_rnd);
        logic [5:0] inc;
        logic [5:0] pick;
        inc  = (cur == num_ani - 6'd1) ? 6'd0 : cur + 6'd1;
        pick = (rnd < num_ani) ? rnd : rnd - num_ani;
        if (use_rnd && (pick != cur)) begin
            return pick;
        end
        return inc;
    endfunction

endpackage

// File: rtl/seq_prescaler.sv
// Frame-rate prescaler: counts 0..PRESCALE-1 while enabled and pulses tick on the last count.
module seq_prescaler #(
    parameter logic [23:0] PRESCALE = 24'd1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [23:0] count;

    assign tick = en && (count == PRESCALE - 24'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? 24'd0 : count + 24'd1;
        end
    end

endmodule

// File: rtl/animation_sequencer.sv
// Animation/frame sequencer for the 7-segment animation engine.
// Optional build macro SEQ_RANDOM_EN selects LFSR-based random animation order.
module animation_sequencer
    import seq_pkg::*;
#(
    parameter logic [23:0] PRESCALE = 24'd1_000_000,
    parameter logic [3:0]  LOOPS    = 4'd3,
    parameter logic [5:0]  NUM_ANI  = NUM_ANI_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       btn_next,
    input  logic       auto_en,
    input  logic [5:0] limit,
    output logic [5:0] animation,
    output logic [5:0] frame,
    output logic       frame_stb,
    output logic       loop_done
);

    state_t     state;
    logic [3:0] loop_cnt;
    logic       btn_q;
    logic       btn_edge;
    logic       tick;
    logic [5:0] nxt;

    assign btn_edge = btn_next & ~btn_q;

`ifdef SEQ_RANDOM_EN
    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign nxt = next_index(animation, NUM_ANI, lfsr, 1'b1);
`else
    assign nxt = next_index(animation, NUM_ANI, 6'd0, 1'b0);
`endif

    // Prescaler holds whenever ena is low, including while parked in S_SWITCH.
    seq_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ena && (state == S_RUN)),
        .clr   (ena && (state == S_SWITCH)),
        .tick  (tick)
    );

    // NOTE: every register here is assigned with <= so all updates see the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            animation <= '0;
            frame     <= '0;
            loop_cnt  <= '0;
            btn_q     <= 1'b0;
            frame_stb <= 1'b0;
            loop_done <= 1'b0;
        end else begin
            btn_q     <= btn_next;
            frame_stb <= 1'b0;
            loop_done <= 1'b0;
            if (!ena) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_SWITCH;
                    end
                    S_SWITCH: begin
                        frame     <= '0;
                        loop_cnt  <= '0;
                        frame_stb <= 1'b1;
                        if (btn_edge) begin
                            animation <= nxt;
                            state     <= S_SWITCH;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        // A button edge wins over a coincident tick, giving a single advance.
                        if (btn_edge) begin
                            animation <= nxt;
                            state     <= S_SWITCH;
                        end else if (tick) begin
                            frame_stb <= 1'b1;
                            if (frame >= limit) begin
                                frame     <= '0;
                                loop_done <= 1'b1;
                                loop_cnt  <= loop_cnt + 4'd1;
                                if (auto_en && (loop_cnt == LOOPS - 4'd1)) begin
                                    animation <= nxt;
                                    state     <= S_SWITCH;
                                end
                            end else begin
                                frame <= frame + 6'd1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_animation_sequencer.sv
// Directed self-checking bench for animation_sequencer (PRESCALE=4, LOOPS=2, NUM_ANI=46).
module tb_animation_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       btn_next;
    logic       auto_en;
    logic [5:0] limit;
    logic [5:0] animation;
    logic [5:0] frame;
    logic       frame_stb;
    logic       loop_done;

    int n_checks = 0;
    int n_fails  = 0;

    animation_sequencer #(
        .PRESCALE (24'd4),
        .LOOPS    (4'd2),
        .NUM_ANI  (6'd46)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .btn_next  (btn_next),
        .auto_en   (auto_en),
        .limit     (limit),
        .animation (animation),
        .frame     (frame),
        .frame_stb (frame_stb),
        .loop_done (loop_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // After this returns, the next rising edge is E1 (S_IDLE -> S_SWITCH).
    task automatic do_reset(input logic [5:0] lim, input logic aen);
        rst_n    = 1'b0;
        ena      = 1'b0;
        btn_next = 1'b0;
        auto_en  = aen;
        limit    = lim;
        step(2);
        rst_n = 1'b1;
        ena   = 1'b1;
    endtask

    task automatic press();
        btn_next = 1'b1;
        step(1);
        btn_next = 1'b0;
        step(1);
    endtask

    initial begin
        int pulses;
        int moved;
        logic [5:0] prev;

        // Reset values and basic frame stepping with limit=5, auto_en=0
        rst_n    = 1'b0;
        ena      = 1'b0;
        btn_next = 1'b0;
        auto_en  = 1'b0;
        limit    = 6'd5;
        step(1);
        check("rst_animation", animation, 0);
        check("rst_frame", frame, 0);
        check("rst_frame_stb", frame_stb, 0);
        check("rst_loop_done", loop_done, 0);
        do_reset(6'd5, 1'b0);
        step(1);
        check("idle_no_stb", frame_stb, 0);
        step(1);
        check("switch_stb", frame_stb, 1);
        check("switch_frame", frame, 0);
        step(3);
        check("run_no_stb", frame_stb, 0);
        step(1);
        check("tick1_frame", frame, 1);
        check("tick1_stb", frame_stb, 1);
        for (int f = 2; f <= 5; f++) begin
            step(4);
            check("tick_frame", frame, f);
        end
        step(4);
        check("wrap_frame", frame, 0);
        check("wrap_loop_done", loop_done, 1);
        check("wrap_stb", frame_stb, 1);
        step(1);
        check("loop_done_pulse", loop_done, 0);
        check("no_auto_animation", animation, 0);

        // Auto-advance after LOOPS=2 wraps with limit=1
        do_reset(6'd1, 1'b1);
        step(2);
        step(8);
        check("auto_first_wrap", loop_done, 1);
        check("auto_first_anim", animation, 0);
        step(8);
        check("auto_second_wrap", loop_done, 1);
        check("auto_advanced", animation, 1);
        check("auto_frame", frame, 0);
        step(1);
        check("auto_switch_stb", frame_stb, 1);
        check("auto_switch_ld", loop_done, 0);
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            if (loop_done) pulses++;
        end
        check("auto_no_early_ld", pulses, 0);
        step(1);
        check("auto_third_ld", loop_done, 1);
        check("auto_third_anim", animation, 1);
        step(4);
        check("pre_async_frame", frame, 1);
        rst_n = 1'b0;
        #2;
        check("async_rst_anim", animation, 0);
        check("async_rst_frame", frame, 0);
        check("async_rst_stb", frame_stb, 0);

        // Button edge coinciding with a tick at the last animation
        do_reset(6'd5, 1'b0);
        step(2);
        for (int i = 0; i < 45; i++) press();
        check("btn_reach_45", animation, 45);
        check("btn_frame_before", frame, 0);
        step(3);
        btn_next = 1'b1;
        step(1);
        check("btn_wrap_anim", animation, 0);
        check("btn_no_incr", frame, 0);
        check("btn_tick_suppr", frame_stb, 0);
        step(1);
        btn_next = 1'b0;
        check("btn_switch_stb", frame_stb, 1);
        check("btn_single_adv", animation, 0);

        // Limit shrinks below the current frame
        do_reset(6'd9, 1'b0);
        step(2);
        step(28);
        check("shrink_pre_frame", frame, 7);
        limit = 6'd3;
        step(4);
        check("shrink_wrap_frame", frame, 0);
        check("shrink_loop_done", loop_done, 1);

        // ena low freezes everything and ignores button edges
        do_reset(6'd5, 1'b0);
        step(2);
        step(8);
        check("freeze_pre_frame", frame, 2);
        ena = 1'b0;
        pulses = 0;
        moved  = 0;
        for (int i = 0; i < 10; i++) begin
            btn_next = (i == 3 || i == 4 || i == 7);
            step(1);
            if (frame_stb || loop_done) pulses++;
            if (frame != 6'd2 || animation != 6'd0) moved++;
        end
        btn_next = 1'b0;
        check("freeze_no_pulses", pulses, 0);
        check("freeze_no_motion", moved, 0);
        ena = 1'b1;
        step(1);
        check("resume_idle_frame", frame, 2);
        step(1);
        check("resume_switch_stb", frame_stb, 1);
        check("resume_frame", frame, 0);
        check("resume_anim", animation, 0);

`ifdef SEQ_RANDOM_EN
        // Random order: every pick in range and different from the previous index
        do_reset(6'd5, 1'b0);
        step(2);
        moved = 0;
        for (int i = 0; i < 200; i++) begin
            prev = animation;
            press();
            if (animation >= 6'd46 || animation == prev) moved++;
        end
        check("random_bad_picks", moved, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
